// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the RAM arbiter
// Purpose: FSM state encoding and requester count used by ram_arbiter and
//          ram_arb_pick.
// Contents:
//   NUM_REQ - number of requesters sharing the RAM (2)
//   state_e - arbiter FSM states IDLE / ACCESS / RDWAIT
package ram_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational two-way winner selection
// Purpose: choose which requester gets the RAM this cycle.
// Ports:
//   req0_i  in  requester 0 wants the RAM
//   req1_i  in  requester 1 wants the RAM
//   last_i  in  index of the requester granted most recently
//   grant_o out one-hot grant (bit n = requester n), all-zero when idle
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // On a tie the requester that was not served last wins; a lone
  // requester always wins regardless of the pointer.
  always_comb begin
    grant_o = '0;
    if (req0_i && (!req1_i || last_i)) begin
      grant_o[0] = 1'b1;
    end else if (req1_i) begin
      grant_o[1] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter in front of a single-port RAM
// Purpose: serialises read/write accesses from two requesters onto one
//          single-port RAM with a registered read port. A write takes two
//          cycles (IDLE, ACCESS), a read three (IDLE, ACCESS, RDWAIT).
//          All outputs are registered.
// Configuration macro:
//   RAM_ARBITER_FIXED_PRIO_EN - defined: requester 0 always wins ties and no
//                               last-grant pointer exists; undefined:
//                               round-robin between the two requesters.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN requester N request, write(1)/read(0), address,
//                            write data (held stable until ackN)
//   ackN                     one-cycle grant pulse to requester N
//   rdataN, rvalidN          read data for requester N and its one-cycle strobe
//   ram_addr, ram_din, ram_we  RAM address, write data, write enable
//   ram_dout                 RAM read data, valid the cycle after the address
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         we0,
  input  logic [A-1:0] addr0,
  input  logic [D-1:0] wdata0,
  output logic         ack0,
  output logic [D-1:0] rdata0,
  output logic         rvalid0,
  input  logic         req1,
  input  logic         we1,
  input  logic [A-1:0] addr1,
  input  logic [D-1:0] wdata1,
  output logic         ack1,
  output logic [D-1:0] rdata1,
  output logic         rvalid1,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout
);

  state_e       state_q, state_d;
  logic [A-1:0] ram_addr_q, ram_addr_d;
  logic [D-1:0] ram_din_q, ram_din_d;
  logic         ram_we_q, ram_we_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         rvalid0_q, rvalid0_d;
  logic         rvalid1_q, rvalid1_d;
  logic [D-1:0] rdata0_q, rdata0_d;
  logic [D-1:0] rdata1_q, rdata1_d;
  // Which requester owns the access in flight (0 or 1).
  logic         sel_q, sel_d;

  logic [NUM_REQ-1:0] grant_w;
  logic               last_w;
  logic               take_w;

  // Requests are only looked at in IDLE, so a request raised and dropped
  // while an access is in flight is never seen.
  assign take_w = (state_q == IDLE) && (grant_w != '0);

  ram_arb_pick u_pick (
    .req0_i  (req0),
    .req1_i  (req1),
    .last_i  (last_w),
    .grant_o (grant_w)
  );

`ifdef RAM_ARBITER_FIXED_PRIO_EN
  // Pointer stuck at "requester 1 served last" so requester 0 wins every tie.
  assign last_w = 1'b1;
`else
  logic last_q, last_d;

  assign last_d = take_w ? grant_w[1] : last_q;

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_w = last_q;
`endif

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    sel_d      = sel_q;

    case (state_q)
      IDLE: begin
        if (take_w) begin
          state_d    = ACCESS;
          sel_d      = grant_w[1];
          ram_addr_d = grant_w[1] ? addr1 : addr0;
          ram_din_d  = grant_w[1] ? wdata1 : wdata0;
          ram_we_d   = grant_w[1] ? we1 : we0;
          ack0_d     = grant_w[0];
          ack1_d     = grant_w[1];
        end
      end
      ACCESS: begin
        // ram_we_q still carries the direction of this access.
        state_d = ram_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // RAM output now reflects the address presented during ACCESS.
        state_d = IDLE;
        if (sel_q) begin
          rdata1_d  = ram_dout;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = ram_dout;
          rvalid0_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      sel_q      <= sel_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard testbench for ram_arbiter
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, we0, req1, we1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int id;
    int addr;
    int data;
    int cyc;
  } ev_t;

  ev_t ack_q[$];
  ev_t rv_q[$];
  ev_t wr_q[$];

  ram_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .rvalid1  (rvalid1),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read. Preloaded with mem[a] = a[7:0].
  logic [7:0] mem [0:1023];
  logic       ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    ev_t e;
    if (reset_n) begin
      if (ack0 && ack1) unexpected("ack_both");
      if (ack0 || ack1) begin
        if (ack_q.size() == 0) unexpected("ack_extra");
        else begin
          e = ack_q.pop_front();
          chk("ack_id", ack1 ? 1 : 0, e.id);
          chk("ack_cyc", cyc, e.cyc);
        end
      end
      if (rvalid0 || rvalid1) begin
        if (rv_q.size() == 0) unexpected("rvalid_extra");
        else begin
          e = rv_q.pop_front();
          chk("rv_id", rvalid1 ? 1 : 0, e.id);
          chk("rv_data", rvalid1 ? int'(rdata1) : int'(rdata0), e.data);
          chk("rv_cyc", cyc, e.cyc);
        end
      end
      if (ram_we) begin
        if (wr_q.size() == 0) unexpected("ram_we_extra");
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", int'(ram_addr), e.addr);
          chk("wr_data", int'(ram_din), e.data);
          chk("wr_cyc", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit en, input bit we,
                         input int addr, input int data);
    if (id == 0) begin
      req0 = en; we0 = we; addr0 = addr[9:0]; wdata0 = data[7:0];
    end else begin
      req1 = en; we1 = we; addr1 = addr[9:0]; wdata1 = data[7:0];
    end
  endtask

  task automatic push(input int kind, input int id, input int addr,
                      input int data, input int c);
    ev_t e;
    e.id = id; e.addr = addr; e.data = data; e.cyc = c;
    if (kind == 0) ack_q.push_back(e);
    else if (kind == 1) rv_q.push_back(e);
    else wr_q.push_back(e);
  endtask

  // One lone access; exp is the read data expected back for a read.
  task automatic single(input int id, input bit we, input int addr,
                        input int data, input int exp);
    int k;
    k = cyc;
    set_req(id, 1'b1, we, addr, data);
    push(0, id, 0, 0, k + 1);
    if (we) push(2, id, addr, data, k + 1);
    else    push(1, id, 0, exp, k + 3);
    tick();
    set_req(id, 1'b0, 1'b0, 0, 0);
    repeat (we ? 2 : 3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack0"}, int'(ack0), 0);
    chk({tag, "_ack1"}, int'(ack1), 0);
    chk({tag, "_rvalid0"}, int'(rvalid0), 0);
    chk({tag, "_rvalid1"}, int'(rvalid1), 0);
    chk({tag, "_rdata0"}, int'(rdata0), 0);
    chk({tag, "_rdata1"}, int'(rdata1), 0);
    chk({tag, "_ram_we"}, int'(ram_we), 0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_ram_din"}, int'(ram_din), 0);
  endtask

  // Grant an access, then pull reset while it sits in ACCESS.
  task automatic abort_in_access(input int id, input bit we, input int addr,
                                 input int data);
    set_req(id, 1'b1, we, addr, data);
    tick();
    chk("abort_ack", id == 0 ? int'(ack0) : int'(ack1), 1);
    chk("abort_ram_we", int'(ram_we), int'(we));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    set_req(id, 1'b0, 1'b0, 0, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int id;
    reset_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 0, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);
    repeat (2) tick();
    ram_ready = 1'b1;
    check_reset_outputs("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Lone write then read-back by requester 0.
    single(0, 1'b1, 10'h005, 8'hA5, 0);
    single(0, 1'b0, 10'h005, 0, 8'hA5);
    chk("rdata0_hold", int'(rdata0), 8'hA5);
    // Lone requester 1 wins; last grant then goes to requester 0.
    single(1, 1'b1, 10'h03C, 8'h5A, 0);
    single(0, 1'b1, 10'h100, 8'h3C, 0);

    // Reset restores the pointer so requester 0 wins the tie.
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset2");
    tick();
    reset_n = 1'b1;
    tick();

    k = cyc;
    set_req(0, 1'b1, 1'b0, 10'h005, 0);
    set_req(1, 1'b1, 1'b0, 10'h03C, 0);
    push(0, 0, 0, 0, k + 1);
    push(1, 0, 0, 8'hA5, k + 3);
    push(0, 1, 0, 0, k + 4);
    push(1, 1, 0, 8'h5A, k + 6);
    tick();
    set_req(0, 1'b0, 1'b0, 0, 0);
    repeat (3) tick();
    set_req(1, 1'b0, 1'b0, 0, 0);
    repeat (3) tick();

    // Both hold writes for 8 grants.
    k = cyc;
    set_req(0, 1'b1, 1'b1, 10'h010, 8'h11);
    set_req(1, 1'b1, 1'b1, 10'h020, 8'h22);
    for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARBITER_FIXED_PRIO_EN
      id = 0;
`else
      id = i % 2;
`endif
      push(0, id, 0, 0, k + 1 + 2 * i);
      push(2, id, id == 0 ? 10'h010 : 10'h020, id == 0 ? 8'h11 : 8'h22, k + 1 + 2 * i);
    end
    repeat (16) tick();
    set_req(0, 1'b0, 1'b0, 0, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);
    repeat (2) tick();

    // Aborted write must not reach the RAM; aborted read gives no rvalid.
    abort_in_access(1, 1'b1, 10'h030, 8'h77);
    abort_in_access(0, 1'b0, 10'h005, 0);

    // Last grant before reset was requester 0, yet 0 wins the tie again.
    k = cyc;
    set_req(0, 1'b1, 1'b0, 10'h3FF, 0);
    set_req(1, 1'b1, 1'b0, 10'h030, 0);
    push(0, 0, 0, 0, k + 1);
    push(1, 0, 0, 8'hFF, k + 3);
    push(0, 1, 0, 0, k + 4);
    push(1, 1, 0, 8'h30, k + 6);
    tick();
    set_req(0, 1'b0, 1'b0, 0, 0);
    repeat (3) tick();
    set_req(1, 1'b0, 1'b0, 0, 0);
    repeat (3) tick();

    // Requester 1 pulses a request only during RDWAIT: never served.
    k = cyc;
    set_req(0, 1'b1, 1'b0, 10'h010, 0);
    push(0, 0, 0, 0, k + 1);
    push(1, 0, 0, 8'h11, k + 3);
    tick();
    set_req(0, 1'b0, 1'b0, 0, 0);
    tick();
    set_req(1, 1'b1, 1'b1, 10'h040, 8'h99);
    tick();
    set_req(1, 1'b0, 1'b0, 0, 0);
    repeat (6) tick();
    chk("rdata0_final", int'(rdata0), 8'h11);
    chk("rdata1_hold", int'(rdata1), 8'h30);
    chk("mem_040_untouched", int'(mem[10'h040]), 8'h40);
    chk("mem_030_untouched", int'(mem[10'h030]), 8'h30);

    chk("ack_q_empty", ack_q.size(), 0);
    chk("rv_q_empty", rv_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter A, default 10, RAM address width in bits.
REQ-002 SHALL have parameter D, default 8, RAM data width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for each requester n in {0,1}: reqn input 1 request; wen input 1 write(1)/read(0); addrn input A; wdatan input D; ackn output 1 grant pulse; rdatan output D read data; rvalidn output 1 read-data pulse.
REQ-006 SHALL have ram_addr output A, ram_din output D, ram_we output 1, and ram_dout input D, connecting to a single-port RAM with a registered read (dout valid the cycle after the address edge).

Function
REQ-007 SHALL use FSM states IDLE, ACCESS, RDWAIT; every output SHALL be registered.
REQ-008 IDLE, cycle N, any reqn high: SHALL pick winner, latch its addr/wdata/we onto ram_addr/ram_din/ram_we, go to ACCESS; no request: stay IDLE, ram_we=0.
REQ-009 Arbitration SHALL be round-robin: when both request, the requester not granted last wins; a lone requester always wins.
REQ-010 ackn SHALL pulse high exactly one cycle (N+1, the ACCESS cycle) for the winner only; ack0 and ack1 SHALL never be high together.
REQ-011 Write: RAM write SHALL commit at the edge ending N+1; ram_we SHALL be high only in ACCESS; FSM SHALL return to IDLE at N+2.
REQ-012 Read: ACCESS -> RDWAIT; in RDWAIT (N+2) ram_dout SHALL be captured into rdatan of the winner; rvalidn SHALL pulse one cycle at N+3; FSM IDLE at N+3.
REQ-013 rdatan SHALL hold its last value until the next read for that requester.
REQ-014 Requesters SHALL hold reqn/wen/addrn/wdatan stable until ackn; reqn still high after ackn SHALL count as a new request; inputs are sampled only in IDLE.
REQ-015 Back-to-back throughput SHALL be one write per 2 cycles and one read per 3 cycles; with both requesting continuously, grants SHALL alternate 0,1,0,1.
REQ-016 A request dropped before its ack SHALL be forgotten without any RAM access.

Reset
REQ-017 reset_n low SHALL immediately force: state IDLE, ram_we=0, ram_addr=0, ram_din=0, ack0/ack1=0, rvalid0/rvalid1=0, rdata0/rdata1=0, last-grant pointer=1 (requester 0 wins the first tie).
REQ-018 Reset mid-operation SHALL abort it: no ack, no rvalid for the aborted access; a write not yet committed SHALL not occur.

Configuration
REQ-019 Macro RAM_ARBITER_FIXED_PRIO_EN defined: requester 0 SHALL always win ties and the last-grant pointer SHALL be removed; undefined: round-robin per REQ-009.

Structure
REQ-020 Shared package ram_arbiter_pkg SHALL hold the FSM state encoding (IDLE/ACCESS/RDWAIT) and the requester-count constant (2).
REQ-021 Winner selection SHALL live in combinational sub-module ram_arb_pick (inputs req0, req1, last-grant pointer; output one-hot grant); the RAM itself is external.

Verification
REQ-022 req0 write addr 0x005 data 0xA5 -> ack0 at N+1, ram_we high N+1 only; later req0 read 0x005 -> rvalid0 at N+3, rdata0=0xA5.
REQ-023 req0 and req1 reads asserted same cycle after reset -> ack0 first, ack1 three cycles later; rvalid0 then rvalid1, each with its own address's data.
REQ-024 Both hold writes continuously for 8 grants -> acks alternate 0,1,0,1...; with RAM_ARBITER_FIXED_PRIO_EN defined -> ack0 every 2 cycles, ack1 never.
REQ-025 reset_n pulsed low during ACCESS of a read -> no rvalid, all outputs 0 per REQ-017, next tie grants requester 0.
REQ-026 req1 raised for one cycle while FSM in RDWAIT, then dropped -> no ack1, no RAM access for requester 1.
